// File: rtl/conv_ctrl.sv
// Sequencer for a 3x3 sliding-window convolution: column intake, window issue,
// credit-limited result buffering and output coordinate tracking.
module conv_ctrl #(
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned CONV_LAT   = 2,
    parameter int unsigned RES_NB     = 19
) (
    input  logic              clk100,
    input  logic              in_reset,
    input  logic              i_start,
    input  logic              i_col_valid,
    output logic              o_col_ready,
    output logic              o_shift,
    output logic              o_win_valid,
    output logic [8:0]        o_row,
    input  logic [RES_NB-1:0] i_pixel,
    output logic [RES_NB-1:0] o_pixel,
    output logic              o_pixel_valid,
    input  logic              i_pixel_ready,
    output logic [9:0]        o_x,
    output logic [8:0]        o_y,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned ROW_W      = 9;
    localparam int unsigned X_W        = 10;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned CRD_W      = 4;
    localparam int unsigned FILL_W     = 2;
    localparam int unsigned FILL_COLS  = 3;
    localparam int unsigned COL_W      = $clog2(IMG_WIDTH + 1);

    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(IMG_HEIGHT - 3);
    localparam logic [X_W-1:0]    LAST_X    = X_W'(IMG_WIDTH - 3);
    localparam logic [COL_W-1:0]  ALL_COLS  = COL_W'(IMG_WIDTH);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_COLS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        NEXT  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic [ROW_W-1:0]    row_q;
    logic [COL_W-1:0]    col_cnt_q;
    logic [FILL_W-1:0]   fill_cnt_q;
    logic [CONV_LAT-1:0] pipe_q;
    logic [CNT_W-1:0]    inflight_q;

    logic [RES_NB-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    fifo_cnt_q;

    logic [X_W-1:0]      x_q;
    logic [ROW_W-1:0]    y_q;

    logic                accept;
    logic                take;
    logic                fifo_wr;
    logic                credit_ok;
    logic                last_take;
    logic                frame_start;

    // Handshake decode and credit check; a take this cycle frees one slot.
    always_comb begin
        accept      = i_col_valid && o_col_ready;
        take        = o_pixel_valid && i_pixel_ready;
        fifo_wr     = pipe_q[CONV_LAT-1];
        credit_ok   = (CRD_W'(fifo_cnt_q) + CRD_W'(inflight_q))
                      < (CRD_W'(FIFO_DEPTH) + CRD_W'(take));
        last_take   = take && (x_q == LAST_X) && (y_q == LAST_ROW);
        frame_start = (state_q == IDLE) && i_start;
    end

    // State register.
    always_ff @(posedge clk100 or negedge in_reset) begin
        if (!in_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control outputs.
    always_comb begin
        state_d     = state_q;
        o_col_ready = 1'b0;
        o_win_valid = 1'b0;
        o_busy      = 1'b1;
        case (state_q)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                o_col_ready = 1'b1;
                if (i_col_valid && (fill_cnt_q == FILL_LAST)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                o_win_valid = credit_ok;
                if (credit_ok && (row_q == LAST_ROW)) begin
                    state_d = (col_cnt_q < ALL_COLS) ? NEXT : DRAIN;
                end
            end
            NEXT: begin
                o_col_ready = 1'b1;
                if (i_col_valid) begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if ((inflight_q == '0) &&
                    ((fifo_cnt_q == '0) || ((fifo_cnt_q == CNT_W'(1)) && take))) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Column intake counters and window row pointer.
    always_ff @(posedge clk100 or negedge in_reset) begin
        if (!in_reset) begin
            fill_cnt_q <= '0;
            col_cnt_q  <= '0;
            row_q      <= '0;
        end else begin
            if (frame_start) begin
                fill_cnt_q <= '0;
                col_cnt_q  <= '0;
                row_q      <= '0;
            end
            if (accept) begin
                col_cnt_q <= col_cnt_q + COL_W'(1);
                if (state_q == FILL) begin
                    fill_cnt_q <= fill_cnt_q + FILL_W'(1);
                end
            end
            if (o_win_valid) begin
                row_q <= (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
            end
        end
    end

    // Datapath latency tracker: one bit per cycle of flight, plus a running count.
    always_ff @(posedge clk100 or negedge in_reset) begin
        if (!in_reset) begin
            pipe_q     <= '0;
            inflight_q <= '0;
        end else begin
            pipe_q[0] <= o_win_valid;
            for (int i = 1; i < int'(CONV_LAT); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            inflight_q <= inflight_q + CNT_W'(o_win_valid) - CNT_W'(fifo_wr);
        end
    end

    // Result FIFO; credits guarantee a write never lands on a full buffer.
    always_ff @(posedge clk100 or negedge in_reset) begin
        if (!in_reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (fifo_wr) begin
                mem_q[wr_ptr_q] <= i_pixel;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (take) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            fifo_cnt_q <= fifo_cnt_q + CNT_W'(fifo_wr) - CNT_W'(take);
        end
    end

    // Output coordinates: y walks down a column, x advances on column wrap.
    always_ff @(posedge clk100 or negedge in_reset) begin
        if (!in_reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            if (frame_start) begin
                x_q <= '0;
                y_q <= '0;
            end
            if (take) begin
                if (y_q == LAST_ROW) begin
                    y_q <= '0;
                    x_q <= (x_q == LAST_X) ? '0 : x_q + X_W'(1);
                end else begin
                    y_q <= y_q + ROW_W'(1);
                end
            end
        end
    end

    // Output mapping.
    always_comb begin
        o_shift       = accept;
        o_row         = row_q;
        o_pixel       = mem_q[rd_ptr_q];
        o_pixel_valid = (fifo_cnt_q != '0);
        o_x           = x_q;
        o_y           = y_q;
        o_done        = last_take;
    end

endmodule

// File: tb/tb_conv_ctrl.sv
// Randomized and directed bench for conv_ctrl against a queue-based frame model.
module tb_conv_ctrl;

    localparam int H      = 5;
    localparam int W      = 4;
    localparam int L      = 2;
    localparam int RES_NB = 19;
    localparam int ROWS   = H - 2;
    localparam int N_OUT  = (W - 2) * (H - 2);

    logic              clk100;
    logic              in_reset;
    logic              i_start;
    logic              i_col_valid;
    logic              o_col_ready;
    logic              o_shift;
    logic              o_win_valid;
    logic [8:0]        o_row;
    logic [RES_NB-1:0] i_pixel;
    logic [RES_NB-1:0] o_pixel;
    logic              o_pixel_valid;
    logic              i_pixel_ready;
    logic [9:0]        o_x;
    logic [8:0]        o_y;
    logic              o_busy;
    logic              o_done;

    conv_ctrl #(
        .IMG_HEIGHT(H),
        .IMG_WIDTH (W),
        .CONV_LAT  (L),
        .RES_NB    (RES_NB)
    ) dut (
        .clk100       (clk100),
        .in_reset     (in_reset),
        .i_start      (i_start),
        .i_col_valid  (i_col_valid),
        .o_col_ready  (o_col_ready),
        .o_shift      (o_shift),
        .o_win_valid  (o_win_valid),
        .o_row        (o_row),
        .i_pixel      (i_pixel),
        .o_pixel      (o_pixel),
        .o_pixel_valid(o_pixel_valid),
        .i_pixel_ready(i_pixel_ready),
        .o_x          (o_x),
        .o_y          (o_y),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    int n_checks;
    int n_fail;

    // Frame model: results waiting downstream, results still in the datapath.
    int q[$];
    bit dp_v[L];
    int dp_s[L];
    int n_issued;
    int n_taken;
    int n_acc;
    int cyc;
    bit done_seen;
    int issue_cyc[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        q.delete();
        issue_cyc.delete();
        for (int i = 0; i < L; i++) begin
            dp_v[i] = 1'b0;
            dp_s[i] = 0;
        end
        n_issued  = 0;
        n_taken   = 0;
        n_acc     = 0;
        done_seen = 1'b0;
    endtask

    // One clock: drive at negedge, check settled outputs, advance the model.
    task automatic do_cycle(input bit st, input bit cv, input bit rdy);
        bit take;
        @(negedge clk100);
        i_start       = st;
        i_col_valid   = cv;
        i_pixel_ready = rdy;
        i_pixel       = dp_v[L-1] ? RES_NB'(dp_s[L-1]) : RES_NB'($urandom);
        #1;
        take = o_pixel_valid && rdy;
        check_eq("shift", 32'(o_shift), 32'(cv && o_col_ready));
        check_eq("pix_valid", 32'(o_pixel_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check_eq("pixel", 32'(o_pixel), 32'(q[0]));
            check_eq("x", 32'(o_x), 32'(n_taken / ROWS));
            check_eq("y", 32'(o_y), 32'(n_taken % ROWS));
        end
        check_eq("done", 32'(o_done), 32'(take && (n_taken == N_OUT - 1)));
        if (o_win_valid) begin
            check_eq("row", 32'(o_row), 32'(n_issued % ROWS));
            check_eq("extra_issue", 32'(n_issued < N_OUT), 32'(1));
        end
        if (o_shift) n_acc++;
        if (take) begin
            void'(q.pop_front());
            n_taken++;
            if (n_taken == N_OUT) done_seen = 1'b1;
        end
        if (dp_v[L-1]) q.push_back(dp_s[L-1]);
        check_eq("fifo_bound", 32'(q.size() <= 4), 32'(1));
        for (int i = L - 1; i > 0; i--) begin
            dp_v[i] = dp_v[i-1];
            dp_s[i] = dp_s[i-1];
        end
        dp_v[0] = o_win_valid;
        dp_s[0] = n_issued;
        if (o_win_valid) begin
            issue_cyc.push_back(cyc);
            n_issued++;
        end
        cyc++;
    endtask

    // cv_mode: 0 high, 1 random, 2 stall in NEXT.  rdy_mode: 0 high, 1 random, 2 toggle, 3 low then high.
    task automatic run_frame(input int cv_mode, input int rdy_mode, input bit start_mid);
        bit cv;
        bit rdy;
        bit st;
        bit pre;
        int stall;
        stall = 0;
        clear_model();
        do_cycle(1'b1, 1'b0, 1'b0);
        for (int b = 0; b < 600 && !done_seen; b++) begin
            cv = (cv_mode == 1) ? ($urandom_range(3) != 0) : 1'b1;
            if (cv_mode == 2 && n_acc == 3) cv = (n_issued == 3 && stall >= 10);
            case (rdy_mode)
                1:       rdy = ($urandom_range(1) != 0);
                2:       rdy = ((cyc % 2) == 1);
                3:       rdy = (b >= 40);
                default: rdy = 1'b1;
            endcase
            if (rdy_mode == 3 && b == 40) begin
                check_eq("hold_issued", 32'(n_issued), 32'(4));
                check_eq("hold_valid", 32'(o_pixel_valid), 32'(1));
                check_eq("hold_pixel", 32'(o_pixel), 32'(0));
            end
            st  = start_mid && (n_issued == 1);
            pre = (cv_mode == 2) && (n_acc == 3) && (n_issued == 3) && (stall < 10);
            do_cycle(st, cv, rdy);
            if (pre) begin
                check_eq("next_win", 32'(o_win_valid), 32'(0));
                check_eq("next_ready", 32'(o_col_ready), 32'(1));
                stall++;
            end
        end
        check_eq("frame_done", 32'(done_seen), 32'(1));
        check_eq("issued", 32'(n_issued), 32'(N_OUT));
        check_eq("accepted", 32'(n_acc), 32'(W));
        check_eq("taken", 32'(n_taken), 32'(N_OUT));
        if (cv_mode == 2) check_eq("stall_cycles", 32'(stall), 32'(10));
        if (cv_mode == 0 && rdy_mode == 0 && issue_cyc.size() == N_OUT) begin
            for (int k = 0; k < N_OUT - 1; k++) begin
                check_eq("issue_gap", 32'(issue_cyc[k+1] - issue_cyc[k]),
                         32'(((k % ROWS) == ROWS - 1) ? 2 : 1));
            end
        end
        do_cycle(1'b0, 1'b1, 1'b1);
        check_eq("idle_busy", 32'(o_busy), 32'(0));
        check_eq("idle_ready", 32'(o_col_ready), 32'(0));
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        cyc           = 0;
        in_reset      = 1'b0;
        i_start       = 1'b0;
        i_col_valid   = 1'b0;
        i_pixel_ready = 1'b0;
        i_pixel       = '0;
        clear_model();
        repeat (3) @(negedge clk100);
        #1;
        check_eq("rst_busy", 32'(o_busy), 32'(0));
        check_eq("rst_pvalid", 32'(o_pixel_valid), 32'(0));
        check_eq("rst_row", 32'(o_row), 32'(0));
        check_eq("rst_xy", 32'({o_x, o_y}), 32'(0));
        in_reset = 1'b1;

        run_frame(0, 0, 1'b0);
        run_frame(0, 3, 1'b0);
        run_frame(2, 0, 1'b0);
        run_frame(0, 2, 1'b0);
        run_frame(0, 0, 1'b1);
        for (int f = 0; f < 4; f++) run_frame(1, 1, 1'b0);

        // Reset asserted mid-RUN.
        clear_model();
        do_cycle(1'b1, 1'b0, 1'b0);
        for (int b = 0; b < 50 && n_issued < 2; b++) do_cycle(1'b0, 1'b1, 1'b1);
        check_eq("reached_run", 32'(n_issued >= 2), 32'(1));
        @(negedge clk100);
        in_reset = 1'b0;
        #1;
        check_eq("mr_busy", 32'(o_busy), 32'(0));
        check_eq("mr_win", 32'(o_win_valid), 32'(0));
        check_eq("mr_ctl", 32'({o_col_ready, o_shift, o_pixel_valid, o_done}), 32'(0));
        check_eq("mr_row", 32'(o_row), 32'(0));
        check_eq("mr_xy", 32'({o_x, o_y}), 32'(0));
        check_eq("mr_pixel", 32'(o_pixel), 32'(0));
        clear_model();
        @(negedge clk100);
        in_reset = 1'b1;
        for (int b = 0; b < 5; b++) begin
            do_cycle(1'b0, 1'b1, 1'b1);
            check_eq("post_busy", 32'(o_busy), 32'(0));
            check_eq("post_ready", 32'(o_col_ready), 32'(0));
        end
        run_frame(0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_ctrl.md
CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 Parameters, one per line: IMG_HEIGHT, 480, rows per column; IMG_WIDTH, 640, columns per frame; CONV_LAT, 2, datapath cycles from window issue to i_pixel valid (1..3); RES_NB, 19, result width.
REQ-002 clk100  in  1  single clock; all logic on rising edge.
REQ-003 in_reset  in  1  asynchronous, active-low reset.
REQ-004 i_start  in  1  one-cycle pulse, starts a frame; ignored unless IDLE.
REQ-005 i_col_valid  in  1  upstream column available.
REQ-006 o_col_ready  out  1  column accepted on cycle where i_col_valid && o_col_ready.
REQ-007 o_shift  out  1  pulse to datapath: shift in accepted column; equals the accept handshake.
REQ-008 o_win_valid  out  1  datapath computes window whose top row is o_row this cycle.
REQ-009 o_row  out  9  top-row index of issued window, 0..IMG_HEIGHT-3.
REQ-010 i_pixel  in  RES_NB  datapath result, valid exactly CONV_LAT cycles after o_win_valid.
REQ-011 o_pixel  out  RES_NB  result at head of output buffer.
REQ-012 o_pixel_valid  out  1  o_pixel valid; held stable until taken.
REQ-013 i_pixel_ready  in  1  downstream takes o_pixel when both high.
REQ-014 o_x  out  10  output column index of o_pixel (0..IMG_WIDTH-3).
REQ-015 o_y  out  9  output row index of o_pixel (0..IMG_HEIGHT-3).
REQ-016 o_busy  out  1  high in every state except IDLE.
REQ-017 o_done  out  1  one-cycle pulse when last pixel of frame is taken.

Function
REQ-018 FSM states IDLE, FILL, RUN, NEXT, DRAIN; IDLE->FILL on i_start.
REQ-019 FILL: o_col_ready high; after 3 accepted columns -> RUN with o_row=0; no windows issued in FILL.
REQ-020 RUN: o_win_valid high each cycle a credit is free; o_row increments per issue; issue at o_row=IMG_HEIGHT-3 ends sweep.
REQ-021 End of sweep: -> NEXT if fewer than IMG_WIDTH columns accepted, else -> DRAIN.
REQ-022 NEXT: o_col_ready high, o_win_valid low; one accepted column -> RUN, o_row=0.
REQ-023 DRAIN: no issue, no column accept; -> IDLE when buffer empty and in-flight count zero; o_done pulses with final take.
REQ-024 o_col_ready low in IDLE, RUN, DRAIN; i_col_valid ignored there.
REQ-025 Output buffer: FIFO, depth 4, captures i_pixel every CONV_LAT-delayed issue; in-order.
REQ-026 Credits: issue allowed only when (FIFO occupancy + in-flight windows) < 4; guarantees no overflow under any i_pixel_ready pattern.
REQ-027 Simultaneous FIFO write and downstream take in one cycle: occupancy unchanged, both effective.
REQ-028 o_x/o_y: start 0,0; after each take o_y increments, wraps to 0 after IMG_HEIGHT-3 with o_x incrementing.
REQ-029 Throughput: with i_pixel_ready held high, one window issued per cycle during RUN.
REQ-030 Frame output count exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2); column accept count exactly IMG_WIDTH.
REQ-031 i_start during non-IDLE state: no effect.

Reset
REQ-032 in_reset low: immediately state IDLE, FIFO and credits empty, counters zero; o_col_ready, o_shift, o_win_valid, o_pixel_valid, o_busy, o_done = 0; o_row, o_x, o_y, o_pixel = 0.
REQ-033 Reset mid-frame: in-flight results discarded; next frame needs new i_start.
REQ-034 Reset release synchronous to clk100 in effect; first state change no earlier than first edge after release.

Verification (IMG_HEIGHT=5, IMG_WIDTH=4, CONV_LAT=2, datapath model: i_pixel = issue sequence number)
REQ-035 Reset asserted mid-RUN -> all outputs zero same cycle; after release o_busy=0, i_col_valid ignored until i_start.
REQ-036 i_start, i_col_valid and i_pixel_ready always high -> 3 accepts then windows o_row 0,1,2 back-to-back, 1 accept, rows 0,1,2; 6 pixels out values 0..5 with (x,y)=(0,0),(0,1),(0,2),(1,0),(1,1),(1,2); o_done with 6th take.
REQ-037 i_pixel_ready low whole frame -> exactly 4 windows issued, o_pixel_valid high, o_pixel=0 held; releasing ready -> remaining 2 issued, all 6 delivered in order.
REQ-038 i_col_valid low for 10 cycles in NEXT -> o_win_valid low throughout, o_col_ready high; resume on accept with o_row=0.
REQ-039 Ready toggled every cycle -> FIFO never exceeds 4, no lost or duplicated pixel, 6 outputs in order.
REQ-040 i_start pulsed during RUN -> ignored; frame completes with exactly 6 outputs and 4 column accepts.
